pl_mem_arbiter: RTL and testbench

//   Shares one single-ported memory bus between the pipeline's instruction-fetch port (IF) and data-memory port (DM).

---
 rtl/pl_mem_arbiter_pkg.sv | 37 +++
 rtl/pl_mem_arbiter_if.sv | 46 ++++
 rtl/pl_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_pl_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_mem_arbiter_pkg.sv
// Shared types for the pipeline memory arbiter: FSM states, bus owner and
// the latched bus request attributes.
package pl_mem_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_REQ,
      ARB_RESP
   } mem_arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_IF,
      OWN_DM
   } mem_owner_t;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_bus_req_t;

   // Builds a bus request record from its fields.
   function automatic mem_bus_req_t mk_bus_req(input logic              we,
                                               input logic [ADDR_W-1:0] addr,
                                               input logic [DATA_W-1:0] wdata);
      mem_bus_req_t r;
      r.we    = we;
      r.addr  = addr;
      r.wdata = wdata;
      return r;
   endfunction

endpackage

// File: rtl/pl_mem_arbiter_if.sv
// Signal bundle between the pipeline requesters (IF, DM), the arbiter and
// the unified memory bus. master = arbiter view, slave = environment view.
interface pl_mem_arbiter_if;
   import pl_mem_arbiter_pkg::*;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;

   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;

   logic              bus_req;
   logic              bus_we;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_gnt;
   logic              bus_rvalid;
   logic [DATA_W-1:0] bus_rdata;

   modport master (
      input  if_req, if_addr,
      output if_gnt, if_rvalid, if_rdata,
      input  dm_req, dm_we, dm_addr, dm_wdata,
      output dm_gnt, dm_rvalid, dm_rdata,
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_gnt, bus_rvalid, bus_rdata
   );

   modport slave (
      output if_req, if_addr,
      input  if_gnt, if_rvalid, if_rdata,
      output dm_req, dm_we, dm_addr, dm_wdata,
      input  dm_gnt, dm_rvalid, dm_rdata,
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_gnt, bus_rvalid, bus_rdata
   );

endinterface

// File: rtl/pl_mem_arbiter.sv
// Pipeline memory arbiter: shares one single-ported memory bus between the
// instruction-fetch (IF) and data-memory (DM) ports, one transaction in flight.
// DM has priority. Optional IF anti-starvation under macro MEM_ARB_FAIRNESS_EN.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | no transaction; arbitrate and latch the winner's attributes
//   ARB_REQ  | bus_req driven with latched attributes, waiting for bus_gnt
//   ARB_RESP | read accepted, waiting for bus_rvalid to route to the owner
module pl_mem_arbiter
   import pl_mem_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic              clk,
   input logic              rst,
   pl_mem_arbiter_if.master mif
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
      $error("STARVE_LIMIT must be in 1..15");
   end

   mem_arb_state_t state_q, state_d;
   mem_owner_t     owner_q, owner_d;
   mem_bus_req_t   attr_q, attr_d;
   logic           bus_req_q, bus_req_d;
   logic           if_first;
   logic           pick_dm;
   logic           pick_if;
   logic           gnt_ok;
   logic           rv_ok;

`ifdef MEM_ARB_FAIRNESS_EN
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
   logic [3:0] starve_q, starve_d;

   assign if_first = mif.if_req && (starve_q >= STARVE_LIM);

   // Counts DM grants taken while IF keeps waiting; saturates at 15.
   always_comb begin
      starve_d = starve_q;
      if (!mif.if_req || mif.if_gnt) begin
         starve_d = 4'd0;
      end else if (mif.dm_gnt && starve_q != 4'hF) begin
         starve_d = starve_q + 4'd1;
      end
   end

   // Starvation counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         starve_q <= 4'd0;
      end else begin
         starve_q <= starve_d;
      end
   end
`else
   assign if_first = 1'b0;
`endif

   assign pick_dm = mif.dm_req && !if_first;
   assign pick_if = mif.if_req && !pick_dm;

   // Next-state, owner and latched bus attributes.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      attr_d    = attr_q;
      bus_req_d = bus_req_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_dm) begin
               attr_d    = mk_bus_req(mif.dm_we, mif.dm_addr, mif.dm_wdata);
               owner_d   = OWN_DM;
               state_d   = ARB_REQ;
               bus_req_d = 1'b1;
            end else if (pick_if) begin
               attr_d    = mk_bus_req(1'b0, mif.if_addr, '0);
               owner_d   = OWN_IF;
               state_d   = ARB_REQ;
               bus_req_d = 1'b1;
            end
         end
         ARB_REQ: begin
            if (mif.bus_gnt) begin
               bus_req_d = 1'b0;
               if (attr_q.we) begin
                  state_d = ARB_IDLE;
                  owner_d = OWN_NONE;
               end else begin
                  state_d = ARB_RESP;
               end
            end
         end
         ARB_RESP: begin
            if (mif.bus_rvalid) begin
               state_d = ARB_IDLE;
               owner_d = OWN_NONE;
            end
         end
         default: begin
            state_d   = ARB_IDLE;
            owner_d   = OWN_NONE;
            bus_req_d = 1'b0;
         end
      endcase
   end

   // FSM and registered bus outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ARB_IDLE;
         owner_q   <= OWN_NONE;
         attr_q    <= '0;
         bus_req_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         attr_q    <= attr_d;
         bus_req_q <= bus_req_d;
      end
   end

   // Handshakes are passed straight through so the requester sees them in the
   // same cycle as the memory; stray bus_gnt/bus_rvalid are masked by state.
   assign gnt_ok = (state_q == ARB_REQ)  && mif.bus_gnt    && !rst;
   assign rv_ok  = (state_q == ARB_RESP) && mif.bus_rvalid && !rst;

   assign mif.if_gnt    = gnt_ok && (owner_q == OWN_IF);
   assign mif.dm_gnt    = gnt_ok && (owner_q == OWN_DM);
   assign mif.if_rvalid = rv_ok  && (owner_q == OWN_IF);
   assign mif.dm_rvalid = rv_ok  && (owner_q == OWN_DM);
   assign mif.if_rdata  = mif.if_rvalid ? mif.bus_rdata : '0;
   assign mif.dm_rdata  = mif.dm_rvalid ? mif.bus_rdata : '0;

   assign mif.bus_req   = bus_req_q;
   assign mif.bus_we    = attr_q.we;
   assign mif.bus_addr  = attr_q.addr;
   assign mif.bus_wdata = attr_q.wdata;

endmodule

// File: tb/tb_pl_mem_arbiter.sv
// Self-checking bench for pl_mem_arbiter: directed vector table, hand-written
// reset/fairness sequences, then random traffic against a transaction model.
module tb_pl_mem_arbiter;
   import pl_mem_arbiter_pkg::*;

   localparam int unsigned STARVE_LIMIT = 4;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   pl_mem_arbiter_if arb_if();

   pl_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk (clk),
      .rst (rst),
      .mif (arb_if)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        bus_req;
      logic        bus_we;
      logic [31:0] bus_addr;
      logic [31:0] bus_wdata;
      logic        if_gnt;
      logic        if_rvalid;
      logic [31:0] if_rdata;
      logic        dm_gnt;
      logic        dm_rvalid;
      logic [31:0] dm_rdata;
   } out_t;

   typedef struct packed {
      logic        if_req;
      logic [31:0] if_addr;
      logic        dm_req;
      logic        dm_we;
      logic [31:0] dm_addr;
      logic [31:0] dm_wdata;
      logic        bus_gnt;
      logic        bus_rvalid;
      logic [31:0] bus_rdata;
   } in_t;

   typedef struct packed {
      in_t  in;
      out_t exp;
   } vec_t;

   function automatic in_t mk_in(logic ir, logic [31:0] ia, logic dr, logic dw,
                                 logic [31:0] da, logic [31:0] dd, logic bg,
                                 logic bv, logic [31:0] bd);
      in_t v;
      v.if_req = ir; v.if_addr = ia; v.dm_req = dr; v.dm_we = dw;
      v.dm_addr = da; v.dm_wdata = dd; v.bus_gnt = bg; v.bus_rvalid = bv;
      v.bus_rdata = bd;
      return v;
   endfunction

   function automatic out_t mk_out(logic br, logic bw, logic [31:0] ba,
                                   logic [31:0] bd, logic ig, logic iv,
                                   logic [31:0] id, logic dg, logic dv,
                                   logic [31:0] dd);
      out_t o;
      o.bus_req = br; o.bus_we = bw; o.bus_addr = ba; o.bus_wdata = bd;
      o.if_gnt = ig; o.if_rvalid = iv; o.if_rdata = id;
      o.dm_gnt = dg; o.dm_rvalid = dv; o.dm_rdata = dd;
      return o;
   endfunction

   function automatic out_t sample_out();
      return mk_out(arb_if.bus_req, arb_if.bus_we, arb_if.bus_addr,
                    arb_if.bus_wdata, arb_if.if_gnt, arb_if.if_rvalid,
                    arb_if.if_rdata, arb_if.dm_gnt, arb_if.dm_rvalid,
                    arb_if.dm_rdata);
   endfunction

   task automatic drive(input in_t v);
      arb_if.if_req     = v.if_req;
      arb_if.if_addr    = v.if_addr;
      arb_if.dm_req     = v.dm_req;
      arb_if.dm_we      = v.dm_we;
      arb_if.dm_addr    = v.dm_addr;
      arb_if.dm_wdata   = v.dm_wdata;
      arb_if.bus_gnt    = v.bus_gnt;
      arb_if.bus_rvalid = v.bus_rvalid;
      arb_if.bus_rdata  = v.bus_rdata;
   endtask

   task automatic check_out(input string name, input out_t exp, input out_t mask);
      out_t act;
      act = sample_out();
      checks++;
      if ((act & mask) !== (exp & mask)) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act & mask, exp & mask);
      end
   endtask

   // One cycle: apply inputs just after the rising edge, compare mid-cycle.
   task automatic step_check(input string name, input in_t v, input out_t exp);
      @(posedge clk); #1;
      drive(v);
      @(negedge clk);
      check_out(name, exp, '1);
   endtask

   function automatic logic [31:0] mem_init_val(logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   vec_t vecs[16];
   in_t  zin;
   out_t zout;
   int   grants[$];

   // random-phase model state
   logic [31:0] mem [logic [31:0]];
   bit          if_pend, dm_pend, dm_w;
   logic [31:0] if_a, dm_a, dm_d;
   bit          tx_active, tx_granted, tx_we;
   int          tx_owner;
   logic [31:0] tx_addr, tx_wdata;
   int          starve;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      zin  = '0;
      zout = '0;
      // inputs: if_req if_addr dm_req dm_we dm_addr dm_wdata gnt rvalid rdata
      vecs[0]  = '{mk_in(1,32'h100,0,0,0,0,0,0,0),            mk_out(0,0,0,0,0,0,0,0,0,0)};
      vecs[1]  = '{mk_in(1,32'h100,0,0,0,0,1,0,0),            mk_out(1,0,32'h100,0,1,0,0,0,0,0)};
      vecs[2]  = '{mk_in(0,0,0,0,0,0,0,1,32'hDEADBEEF),       mk_out(0,0,32'h100,0,0,1,32'hDEADBEEF,0,0,0)};
      vecs[3]  = '{mk_in(1,32'h300,1,1,32'h2000,32'h55,0,0,0), mk_out(0,0,32'h100,0,0,0,0,0,0,0)};
      vecs[4]  = '{mk_in(1,32'h300,1,1,32'h2000,32'h55,1,0,0), mk_out(1,1,32'h2000,32'h55,0,0,0,1,0,0)};
      vecs[5]  = '{mk_in(1,32'h300,0,0,0,0,0,0,0),            mk_out(0,1,32'h2000,32'h55,0,0,0,0,0,0)};
      vecs[6]  = '{mk_in(1,32'h300,0,0,0,0,1,0,0),            mk_out(1,0,32'h300,0,1,0,0,0,0,0)};
      vecs[7]  = '{mk_in(0,0,0,0,0,0,1,0,0),                  mk_out(0,0,32'h300,0,0,0,0,0,0,0)};
      vecs[8]  = '{mk_in(0,0,0,0,0,0,0,1,32'h12345678),       mk_out(0,0,32'h300,0,0,1,32'h12345678,0,0,0)};
      vecs[9]  = '{mk_in(0,0,1,0,32'h40,0,0,1,32'hAAAA0000),  mk_out(0,0,32'h300,0,0,0,0,0,0,0)};
      vecs[10] = '{mk_in(0,0,1,0,32'h40,0,0,1,32'hBBBB0000),  mk_out(1,0,32'h40,0,0,0,0,0,0,0)};
      vecs[11] = '{mk_in(0,0,1,0,32'h40,0,0,0,0),             mk_out(1,0,32'h40,0,0,0,0,0,0,0)};
      vecs[12] = '{mk_in(0,0,1,0,32'h40,0,0,0,0),             mk_out(1,0,32'h40,0,0,0,0,0,0,0)};
      vecs[13] = '{mk_in(0,0,1,0,32'h40,0,1,0,0),             mk_out(1,0,32'h40,0,0,0,0,1,0,0)};
      vecs[14] = '{mk_in(0,0,0,0,0,0,0,1,32'hCAFEF00D),       mk_out(0,0,32'h40,0,0,0,0,0,1,32'hCAFEF00D)};
      vecs[15] = '{mk_in(0,0,0,0,0,0,0,1,32'h11110000),       mk_out(0,0,32'h40,0,0,0,0,0,0,0)};

      // reset
      rst = 1'b1;
      drive(zin);
      @(posedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      check_out("reset_state", zout, '1);
      @(posedge clk); #1;
      rst = 1'b0;

      // directed table: zero-wait read, DM-over-IF, wait states, stray handshakes
      for (int i = 0; i < 16; i++) begin
         step_check($sformatf("vec%0d", i), vecs[i].in, vecs[i].exp);
      end

      // reset while a read is outstanding; the late response must be ignored
      step_check("rst_a_latch", mk_in(1,32'h500,0,0,0,0,0,0,0), mk_out(0,0,32'h40,0,0,0,0,0,0,0));
      step_check("rst_b_gnt",   mk_in(1,32'h500,0,0,0,0,1,0,0), mk_out(1,0,32'h500,0,1,0,0,0,0,0));
      @(posedge clk); #1;
      drive(zin);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      drive(mk_in(0,0,0,0,0,0,0,1,32'hBAD0BAD0));
      @(negedge clk);
      check_out("rst_late_rvalid", zout, '1);
      step_check("rst_idle_latch",  mk_in(0,0,1,0,32'h44,0,0,0,0), zout);
      // DM drops its request after being latched: the transaction still completes
      step_check("drop_req_gnt",    mk_in(0,0,0,0,0,0,1,0,0), mk_out(1,0,32'h44,0,0,0,0,1,0,0));
      step_check("drop_req_rvalid", mk_in(0,0,0,0,0,0,0,1,32'h77), mk_out(0,0,32'h44,0,0,0,0,0,1,32'h77));

      // both ports held requesting with a zero-wait memory
      @(posedge clk); #1;
      drive(mk_in(1,32'h90,1,1,32'h80,32'h9,1,1,32'h1234));
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (arb_if.if_gnt) grants.push_back(1);
         if (arb_if.dm_gnt) grants.push_back(2);
         @(posedge clk); #1;
      end
`ifdef MEM_ARB_FAIRNESS_EN
      checks++;
      if (grants.size() < 10) begin
         errors++;
         $display("FAIL fair_count: got %0d grants expected at least 10", grants.size());
      end else begin
         for (int k = 0; k < 10; k++) begin
            checks++;
            if (grants[k] != (((k % (STARVE_LIMIT + 1)) == STARVE_LIMIT) ? 1 : 2)) begin
               errors++;
               $display("FAIL fair_order%0d: got owner %0d expected %0d", k, grants[k],
                        ((k % (STARVE_LIMIT + 1)) == STARVE_LIMIT) ? 1 : 2);
            end
         end
      end
`else
      begin
         int n_if;
         int n_dm;
         n_if = 0;
         n_dm = 0;
         foreach (grants[k]) begin
            if (grants[k] == 1) n_if++;
            else n_dm++;
         end
         checks++;
         if (n_if != 0) begin
            errors++;
            $display("FAIL strict_if_starved: got %0d IF grants expected 0", n_if);
         end
         checks++;
         if (n_dm < 10) begin
            errors++;
            $display("FAIL strict_dm_grants: got %0d DM grants expected at least 10", n_dm);
         end
      end
`endif

      // random traffic against the transaction-level model
      drive(zin);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      if_pend = 0; dm_pend = 0; dm_w = 0;
      if_a = 0; dm_a = 0; dm_d = 0;
      tx_active = 0; tx_granted = 0; tx_we = 0; tx_owner = 0;
      tx_addr = 0; tx_wdata = 0; starve = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         bit          d_if, d_dm, d_gnt, d_rv, act0, grant_c, rv_c, pick_if;
         logic [31:0] d_rdata;
         out_t        exp, mask;
         int          starve0;
         @(posedge clk); #1;
         if (!if_pend && $urandom_range(0, 2) == 0) begin
            if_pend = 1;
            if_a    = 32'($urandom_range(0, 15)) << 2;
         end
         if (!dm_pend && $urandom_range(0, 2) == 0) begin
            dm_pend = 1;
            dm_w    = 1'($urandom_range(0, 1));
            dm_a    = 32'($urandom_range(0, 15)) << 2;
            dm_d    = $urandom;
         end
         d_if  = if_pend;
         d_dm  = dm_pend;
         d_gnt = ($urandom_range(0, 2) != 0);
         if (tx_active && tx_granted) d_rv = 1'($urandom_range(0, 1));
         else                         d_rv = ($urandom_range(0, 7) == 0);
         if (d_rv && tx_active && tx_granted)
            d_rdata = mem.exists(tx_addr) ? mem[tx_addr] : mem_init_val(tx_addr);
         else
            d_rdata = $urandom;
         drive(mk_in(d_if, d_if ? if_a : $urandom, d_dm, dm_w,
                     d_dm ? dm_a : $urandom, dm_d, d_gnt, d_rv, d_rdata));
         @(negedge clk);

         act0    = tx_active;
         starve0 = starve;
         grant_c = tx_active && !tx_granted && d_gnt;
         rv_c    = tx_active && tx_granted && d_rv;
         exp  = mk_out(tx_active && !tx_granted, tx_we, tx_addr, tx_wdata,
                       grant_c && tx_owner == 1, rv_c && tx_owner == 1,
                       (rv_c && tx_owner == 1) ? d_rdata : 32'h0,
                       grant_c && tx_owner == 2, rv_c && tx_owner == 2,
                       (rv_c && tx_owner == 2) ? d_rdata : 32'h0);
         mask = '1;
         if (!(tx_active && !tx_granted)) begin
            mask.bus_we    = 1'b0;
            mask.bus_addr  = '0;
            mask.bus_wdata = '0;
         end
         check_out($sformatf("rand_cyc%0d", cyc), exp, mask);

         if (grant_c) begin
            tx_granted = 1;
            if (tx_owner == 1) if_pend = 0;
            else               dm_pend = 0;
            if (tx_we) begin
               mem[tx_addr] = tx_wdata;
               tx_active    = 0;
            end
         end
         if (rv_c) tx_active = 0;
         if (!d_if || (grant_c && tx_owner == 1)) starve = 0;
         else if (grant_c && tx_owner == 2 && starve < 15) starve++;

         if (!act0 && (d_if || d_dm)) begin
            pick_if = !d_dm;
`ifdef MEM_ARB_FAIRNESS_EN
            if (d_if && starve0 >= STARVE_LIMIT) pick_if = 1;
`endif
            tx_active  = 1;
            tx_granted = 0;
            if (pick_if) begin
               tx_owner = 1; tx_we = 0; tx_addr = if_a; tx_wdata = 0;
            end else begin
               tx_owner = 2; tx_we = dm_w; tx_addr = dm_a; tx_wdata = dm_d;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
